// File: rtl/switch_matrix_pkg.sv
// Shared types and default sizing for the switch-to-matrix router.
// Cell configuration record, configuration FSM states and index-width helper.
package switch_matrix_pkg;

    localparam int PLAYERS_DEF         = 2;
    localparam int SW_WIDTH_DEF        = 8;
    localparam int MATRIX_WIDTH_DEF    = 16;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Stored source field is wide enough for any practical source count.
    localparam int CFG_SRC_MAX_W = 16;

    typedef enum logic {
        CFG_IDLE   = 1'b0,
        CFG_COMMIT = 1'b1
    } cfg_state_t;

    typedef struct packed {
        logic                     enable;
        logic                     invert;
        logic                     toggle;
        logic [CFG_SRC_MAX_W-1:0] src;
    } cell_cfg_t;

    localparam cell_cfg_t CELL_CFG_RESET = '0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_matrix_router_debounce.sv
// One switch bit: two-flop synchroniser followed by a consecutive-disagreement debouncer.
// The output only moves after the synchronised value has disagreed for DEBOUNCE_CYCLES cycles.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_deb
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_deb) begin
                if (r_cnt == CNT_TC) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/switch_matrix_router.sv
// Routes debounced switch banks onto matrix cells through a per-cell config table.
// Config writes go through a two-state handshake FSM; toggle cells latch on press edges.
//
//   state      | meaning
//   CFG_IDLE   | cfg_ready high, waiting for a configuration write
//   CFG_COMMIT | captured write lands in the cell table, then back to idle
module switch_matrix_router
    import switch_matrix_pkg::*;
#(
    parameter  int PLAYERS         = PLAYERS_DEF,
    parameter  int SW_WIDTH        = SW_WIDTH_DEF,
    parameter  int MATRIX_WIDTH    = MATRIX_WIDTH_DEF,
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    localparam int NSRC            = PLAYERS * SW_WIDTH,
    localparam int SRC_W           = idx_width(NSRC),
    localparam int ADDR_W          = idx_width(MATRIX_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         switches,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [SRC_W-1:0]        cfg_src,
    input  logic                    cfg_enable,
    input  logic                    cfg_invert,
    input  logic                    cfg_toggle,
    output logic [MATRIX_WIDTH-1:0] matrix
);

    logic [NSRC-1:0]         w_deb;
    logic [NSRC-1:0]         w_rise;
    logic [NSRC-1:0]         r_deb_q;

    cfg_state_t              r_state;
    cfg_state_t              w_state_nxt;
    logic                    w_accept;
    logic                    w_commit;
    logic [ADDR_W-1:0]       r_cap_addr;
    cell_cfg_t               r_cap_cfg;
    cell_cfg_t               r_tab [MATRIX_WIDTH];

    logic [MATRIX_WIDTH-1:0] w_hit;
    logic [MATRIX_WIDTH-1:0] w_sel_deb;
    logic [MATRIX_WIDTH-1:0] w_sel_rise;
    logic [MATRIX_WIDTH-1:0] w_tstate_nxt;
    logic [MATRIX_WIDTH-1:0] w_matrix_nxt;
    logic [MATRIX_WIDTH-1:0] r_tstate;
    logic [MATRIX_WIDTH-1:0] r_matrix;

    for (genvar g = 0; g < NSRC; g++) begin : g_deb
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clk(clk),
            .i_rst(rst),
            .i_sw (switches[g]),
            .o_deb(w_deb[g])
        );
    end

    assign w_rise    = w_deb & ~r_deb_q;
    assign cfg_ready = !rst && (r_state == CFG_IDLE);
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_commit  = (r_state == CFG_COMMIT);
    assign matrix    = r_matrix;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CFG_IDLE:   if (w_accept) w_state_nxt = CFG_COMMIT;
            CFG_COMMIT: w_state_nxt = CFG_IDLE;
            default:    w_state_nxt = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= CFG_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Out-of-range sources are stored disabled so the cell can never drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_addr <= '0;
            r_cap_cfg  <= CELL_CFG_RESET;
        end else if (w_accept) begin
            r_cap_addr       <= cfg_addr;
            r_cap_cfg.enable <= cfg_enable && (int'(cfg_src) < NSRC);
            r_cap_cfg.invert <= cfg_invert;
            r_cap_cfg.toggle <= cfg_toggle;
            r_cap_cfg.src    <= CFG_SRC_MAX_W'(cfg_src);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MATRIX_WIDTH; i++) r_tab[i] <= CELL_CFG_RESET;
        end else begin
            for (int i = 0; i < MATRIX_WIDTH; i++) begin
                if (w_hit[i]) r_tab[i] <= r_cap_cfg;
            end
        end
    end

    // A commit to a cell overrides a toggle edge arriving in the same cycle.
    always_comb begin
        w_sel_deb    = '0;
        w_sel_rise   = '0;
        w_hit        = '0;
        w_tstate_nxt = '0;
        w_matrix_nxt = '0;
        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            for (int j = 0; j < NSRC; j++) begin
                if (int'(r_tab[i].src) == j) begin
                    w_sel_deb[i]  = w_deb[j];
                    w_sel_rise[i] = w_rise[j];
                end
            end
            w_hit[i]        = w_commit && (int'(r_cap_addr) == i);
            w_tstate_nxt[i] = w_hit[i] ? 1'b0 : (r_tstate[i] ^ w_sel_rise[i]);
            if (r_tab[i].enable) begin
                w_matrix_nxt[i] = (r_tab[i].toggle ? w_tstate_nxt[i] : w_sel_deb[i])
                                  ^ r_tab[i].invert;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_q  <= '0;
            r_tstate <= '0;
            r_matrix <= '0;
        end else begin
            r_deb_q  <= w_deb;
            r_tstate <= w_tstate_nxt;
            r_matrix <= w_matrix_nxt;
        end
    end

endmodule

// File: tb/tb_switch_matrix_router.sv
// Bench for switch_matrix_router: directed scenarios with fixed expectations plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_switch_matrix_router;

    // 15 sources and 12 cells leave codes 15 (src) and 12..15 (addr) out of range.
    localparam int PLAYERS  = 3;
    localparam int SW_WIDTH = 5;
    localparam int NSRC     = PLAYERS * SW_WIDTH;
    localparam int MW       = 12;
    localparam int DC       = 4;
    localparam int SRC_W    = 4;
    localparam int ADDR_W   = 4;

    logic              clk;
    logic              rst;
    logic [NSRC-1:0]   switches;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [SRC_W-1:0]  cfg_src;
    logic              cfg_enable;
    logic              cfg_invert;
    logic              cfg_toggle;
    logic [MW-1:0]     matrix;

    int total = 0;
    int bad   = 0;

    switch_matrix_router #(
        .PLAYERS(PLAYERS),
        .SW_WIDTH(SW_WIDTH),
        .MATRIX_WIDTH(MW),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switches(switches),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr),
        .cfg_src(cfg_src),
        .cfg_enable(cfg_enable),
        .cfg_invert(cfg_invert),
        .cfg_toggle(cfg_toggle),
        .matrix(matrix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: synchronised view lags raw input by two samples; the accepted
    // value flips after DC consecutive disagreeing samples.
    bit       m_s1 [NSRC];
    bit       m_s2 [NSRC];
    bit       m_deb [NSRC];
    bit       m_debq [NSRC];
    int       m_run [NSRC];
    bit       m_en [MW];
    bit       m_inv [MW];
    bit       m_tog [MW];
    bit       m_tst [MW];
    int       m_src [MW];
    bit       m_busy;
    int       m_cap_addr;
    int       m_cap_src;
    bit       m_cap_en, m_cap_inv, m_cap_tog;
    logic [MW-1:0] m_matrix = '0;

    task automatic model_step();
        bit nd [NSRC];
        bit sd, sr, tn;
        if (rst === 1'b1) begin
            for (int s = 0; s < NSRC; s++) begin
                m_s1[s] = 0; m_s2[s] = 0; m_deb[s] = 0; m_debq[s] = 0; m_run[s] = 0;
            end
            for (int i = 0; i < MW; i++) begin
                m_en[i] = 0; m_inv[i] = 0; m_tog[i] = 0; m_tst[i] = 0; m_src[i] = 0;
            end
            m_busy   = 0;
            m_matrix = '0;
            return;
        end
        for (int s = 0; s < NSRC; s++) begin
            nd[s] = m_deb[s];
            if (m_s2[s] != m_deb[s]) begin
                m_run[s]++;
                if (m_run[s] == DC) begin
                    nd[s]    = m_s2[s];
                    m_run[s] = 0;
                end
            end else begin
                m_run[s] = 0;
            end
        end
        for (int i = 0; i < MW; i++) begin
            sd = 0;
            sr = 0;
            if (m_src[i] < NSRC) begin
                sd = m_deb[m_src[i]];
                sr = m_deb[m_src[i]] && !m_debq[m_src[i]];
            end
            tn = (m_busy && m_cap_addr == i) ? 1'b0 : (m_tst[i] ^ sr);
            m_matrix[i] = m_en[i] ? ((m_tog[i] ? tn : sd) ^ m_inv[i]) : 1'b0;
            m_tst[i] = tn;
        end
        if (m_busy && m_cap_addr < MW) begin
            m_en[m_cap_addr]  = m_cap_en && (m_cap_src < NSRC);
            m_inv[m_cap_addr] = m_cap_inv;
            m_tog[m_cap_addr] = m_cap_tog;
            m_src[m_cap_addr] = m_cap_src;
        end
        for (int s = 0; s < NSRC; s++) begin
            m_debq[s] = m_deb[s];
            m_deb[s]  = nd[s];
            m_s2[s]   = m_s1[s];
            m_s1[s]   = switches[s];
        end
        if (m_busy) begin
            m_busy = 0;
        end else if (cfg_valid) begin
            m_busy     = 1;
            m_cap_addr = int'(cfg_addr);
            m_cap_src  = int'(cfg_src);
            m_cap_en   = cfg_enable;
            m_cap_inv  = cfg_invert;
            m_cap_tog  = cfg_toggle;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cfg_write(input int addr, input int src, input bit en, input bit inv,
                             input bit tog);
        int waited = 0;
        while (cfg_ready !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL cfg_ready_wait got=%b want=1", cfg_ready);
        end
        cfg_valid  = 1'b1;
        cfg_addr   = ADDR_W'(addr);
        cfg_src    = SRC_W'(src);
        cfg_enable = en;
        cfg_invert = inv;
        cfg_toggle = tog;
        tick();
        cfg_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        switches = '1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (matrix !== '0) begin
                bad++;
                $display("FAIL reset_matrix got=%h want=000", matrix);
            end
            total++;
            if (cfg_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_ready got=%b want=0", cfg_ready);
            end
        end
        rst      = 1'b0;
        switches = '0;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready got=%b want=1", cfg_ready);
        end
        for (int k = 0; k < 8; k++) tick();
        total++;
        if (matrix !== '0) begin
            bad++;
            $display("FAIL post_reset_matrix got=%h want=000", matrix);
        end
    endtask

    task automatic test_direct_map();
        logic [MW-1:0] exp;
        cfg_write(5, 10, 1, 0, 0);
        tick();
        total++;
        if (matrix !== 12'h000) begin
            bad++;
            $display("FAIL direct_idle got=%h want=000", matrix);
        end
        switches[10] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = (k < 7) ? 12'h000 : 12'h020;
            total++;
            if (matrix !== exp) begin
                bad++;
                $display("FAIL direct_latency edge=N+%0d got=%h want=%h", k - 1, matrix, exp);
            end
        end
        switches[10] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        total++;
        if (matrix !== 12'h000) begin
            bad++;
            $display("FAIL direct_release got=%h want=000", matrix);
        end
    endtask

    task automatic test_glitch();
        bit seen;
        switches[10] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        switches[10] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (matrix !== 12'h000) begin
                bad++;
                $display("FAIL glitch3 got=%h want=000", matrix);
            end
        end
        seen = 0;
        switches[10] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (matrix[5]) seen = 1;
        end
        switches[10] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (matrix[5]) seen = 1;
        end
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("FAIL pulse4_passes got=%b want=1", seen);
        end
        total++;
        if (matrix !== 12'h000) begin
            bad++;
            $display("FAIL pulse4_settle got=%h want=000", matrix);
        end
    endtask

    task automatic test_toggle_invert();
        logic [MW-1:0] exp;
        logic [MW-1:0] lvl;
        cfg_write(0, 0, 1, 1, 1);
        tick();
        total++;
        if (matrix !== 12'h001) begin
            bad++;
            $display("FAIL toggle_init got=%h want=001", matrix);
        end
        lvl = 12'h001;
        for (int p = 0; p < 2; p++) begin
            switches[0] = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                tick();
                exp = (k < 7) ? lvl : (lvl ^ 12'h001);
                total++;
                if (matrix !== exp) begin
                    bad++;
                    $display("FAIL toggle_press%0d k=%0d got=%h want=%h", p, k, matrix, exp);
                end
            end
            lvl = lvl ^ 12'h001;
            switches[0] = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                total++;
                if (matrix !== lvl) begin
                    bad++;
                    $display("FAIL toggle_release%0d k=%0d got=%h want=%h", p, k, matrix, lvl);
                end
            end
        end
    endtask

    task automatic test_handshake();
        int accepts = 0;
        cfg_valid  = 1'b1;
        cfg_addr   = 4'd1;
        cfg_src    = 4'd1;
        cfg_enable = 1'b1;
        cfg_invert = 1'b0;
        cfg_toggle = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (cfg_ready === 1'b1) accepts++;
            tick();
        end
        cfg_valid = 1'b0;
        tick();
        tick();
        total++;
        if (accepts !== 3) begin
            bad++;
            $display("FAIL held_valid_accepts got=%0d want=3", accepts);
        end
        cfg_write(13, 1, 1, 1, 0);
        cfg_write(15, 1, 1, 1, 0);
        tick();
        total++;
        if (matrix !== 12'h001) begin
            bad++;
            $display("FAIL addr_out_of_range got=%h want=001", matrix);
        end
        cfg_write(3, 2, 1, 1, 0);
        tick();
        total++;
        if (matrix !== 12'h009) begin
            bad++;
            $display("FAIL src_in_range got=%h want=009", matrix);
        end
        cfg_write(3, 15, 1, 1, 0);
        tick();
        total++;
        if (matrix !== 12'h001) begin
            bad++;
            $display("FAIL src_out_of_range got=%h want=001", matrix);
        end
    endtask

    task automatic test_random();
        logic exp_ready;
        for (int c = 0; c < 600; c++) begin
            for (int s = 0; s < NSRC; s++) begin
                if ($urandom_range(0, 15) == 0) switches[s] = ~switches[s];
            end
            rst        = ($urandom_range(0, 149) == 0);
            cfg_valid  = ($urandom_range(0, 9) < 3);
            cfg_addr   = ADDR_W'($urandom_range(0, 15));
            cfg_src    = SRC_W'($urandom_range(0, 15));
            cfg_enable = ($urandom_range(0, 3) != 0);
            cfg_invert = $urandom_range(0, 1) == 1;
            cfg_toggle = $urandom_range(0, 1) == 1;
            tick();
            exp_ready = !rst && !m_busy;
            total++;
            if (matrix !== m_matrix) begin
                bad++;
                $display("FAIL random_matrix cycle=%0d got=%h want=%h", c, matrix, m_matrix);
            end
            total++;
            if (cfg_ready !== exp_ready) begin
                bad++;
                $display("FAIL random_ready cycle=%0d got=%b want=%b", c, cfg_ready, exp_ready);
            end
        end
        rst       = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        switches   = '0;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_src    = '0;
        cfg_enable = 1'b0;
        cfg_invert = 1'b0;
        cfg_toggle = 1'b0;
        test_reset();
        test_direct_map();
        test_glitch();
        test_toggle_invert();
        test_handshake();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
